// File: rtl/pc_sequencer.sv
// Program counter owner: selects PC+4, taken-branch target or hold, and stalls
// fetch around a multi-cycle multiply. Optional macro: PC_MISALIGN_TRAP_EN.
//
// state    | meaning
// RUN      | normal fetch; PC advances or branches every enabled cycle
// MUL_WAIT | multiplier launched; fetch stalled until mul_done or timeout
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MUL_TIMEOUT = 32,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        branch,
  input  logic        zero_flag,
  input  logic [31:0] branch_target,
  input  logic        is_mul,
  input  logic        mul_done,
  output logic [31:0] pc,
`ifdef PC_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        mul_start,
  output logic        stall,
  output logic        flush,
  output logic        mul_err
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(MUL_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        start_q, start_nxt;
  logic        flush_q, flush_nxt;
  logic        err_nxt;
`ifdef PC_MISALIGN_TRAP_EN
  logic        mis_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      cnt      <= 8'd0;
      start_q  <= 1'b0;
      flush_q  <= 1'b0;
      mul_err  <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
    end else if (en) begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      cnt      <= cnt_nxt;
      start_q  <= start_nxt;
      flush_q  <= flush_nxt;
      mul_err  <= err_nxt;
`ifdef PC_MISALIGN_TRAP_EN
      misalign <= mis_nxt;
`endif
    end else begin
      // pulses are dropped rather than held so they cannot replay after en returns
      start_q <= 1'b0;
      flush_q <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    start_nxt = 1'b0;
    flush_nxt = 1'b0;
    err_nxt   = mul_err;
`ifdef PC_MISALIGN_TRAP_EN
    mis_nxt   = misalign;
`endif
    case (state)
      RUN: begin
        if (branch && zero_flag) begin
          flush_nxt = 1'b1;
          pc_nxt    = branch_target & ~32'h3;
`ifdef PC_MISALIGN_TRAP_EN
          if (branch_target[1:0] != 2'b00) begin
            pc_nxt  = TRAP_VEC;
            mis_nxt = 1'b1;
          end
`endif
        end else if (is_mul) begin
          start_nxt = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = MUL_WAIT;
        end else begin
          pc_nxt = pc + 32'd4;
        end
      end
      MUL_WAIT: begin
        if (mul_done) begin
          pc_nxt    = pc + 32'd4;
          state_nxt = RUN;
        end else if (cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          pc_nxt    = pc + 32'd4;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign stall     = (state == MUL_WAIT);
  assign mul_start = start_q & en;
  assign flush     = flush_q & en;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: behavioural reference model compared every
// cycle, plus literal expectations at key points of each scenario.
module tb_pc_sequencer;
  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam int          TO   = 8;
  localparam logic [31:0] TRAP = 32'h0000_0100;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1, branch = 1'b0, zero_flag = 1'b0, is_mul = 1'b0, mul_done = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] pc;
  logic        mul_start, stall, flush, mul_err;
  logic        misalign;

  int checks = 0;
  int failures = 0;
  int n_stall = 0;
  int n_start = 0;

  pc_sequencer #(.RESET_PC(RPC), .MUL_TIMEOUT(TO), .TRAP_VEC(TRAP)) dut (
    .clk(clk), .rst(rst), .en(en), .branch(branch), .zero_flag(zero_flag),
    .branch_target(branch_target), .is_mul(is_mul), .mul_done(mul_done),
    .pc(pc),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign(misalign),
`endif
    .mul_start(mul_start), .stall(stall), .flush(flush), .mul_err(mul_err)
  );

`ifndef PC_MISALIGN_TRAP_EN
  assign misalign = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference model: a busy flag with a remaining-cycle budget for the multiply.
  logic [31:0] m_pc;
  logic        m_busy, m_start, m_flush, m_err, m_mis;
  int          m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= RPC; m_busy <= 1'b0; m_left <= 0;
      m_start <= 1'b0; m_flush <= 1'b0; m_err <= 1'b0; m_mis <= 1'b0;
    end else if (en) begin
      m_start <= 1'b0;
      m_flush <= 1'b0;
      if (m_busy) begin
        if (mul_done || m_left == 1) begin
          m_pc   <= m_pc + 32'd4;
          m_busy <= 1'b0;
          if (!mul_done) m_err <= 1'b1;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (branch && zero_flag) begin
        m_flush <= 1'b1;
        if (TRAP_ON && branch_target[1:0] != 2'b00) begin
          m_pc  <= TRAP;
          m_mis <= 1'b1;
        end else begin
          m_pc <= {branch_target[31:2], 2'b00};
        end
      end else if (is_mul) begin
        m_start <= 1'b1;
        m_busy  <= 1'b1;
        m_left  <= TO;
      end else begin
        m_pc <= m_pc + 32'd4;
      end
    end else begin
      m_start <= 1'b0;
      m_flush <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("model_pc", pc, m_pc);
      check("model_stall", {31'd0, stall}, {31'd0, m_busy});
      check("model_mul_start", {31'd0, mul_start}, {31'd0, m_start & en});
      check("model_flush", {31'd0, flush}, {31'd0, m_flush & en});
      check("model_mul_err", {31'd0, mul_err}, {31'd0, m_err});
      if (TRAP_ON) check("model_misalign", {31'd0, misalign}, {31'd0, m_mis});
      if (stall) n_stall++;
      if (mul_start) n_start++;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic take_branch(input logic [31:0] tgt);
    branch = 1'b1; zero_flag = 1'b1; branch_target = tgt;
    step();
    branch = 1'b0; zero_flag = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog pc=%h stall=%b", pc, stall);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("reset_pc_async", pc, RPC);
    check("reset_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check("reset_pc", pc, 32'h0);
    check("reset_flush", {31'd0, flush}, 32'd0);

    // straight-line
    for (int i = 1; i <= 4; i++) begin
      step();
      check("straight_pc", pc, 32'(4 * i));
    end

    // branch truth table from pc=0x10
    branch_target = 32'h2000;
    {branch, zero_flag} = 2'b00; step(); check("br00_pc", pc, 32'h14);
    {branch, zero_flag} = 2'b01; step(); check("br01_pc", pc, 32'h18);
    {branch, zero_flag} = 2'b10; step(); check("br10_pc", pc, 32'h1C);
    check("br10_flush", {31'd0, flush}, 32'd0);
    {branch, zero_flag} = 2'b11; step(); check("br11_pc", pc, 32'h2000);
    check("br11_flush", {31'd0, flush}, 32'd1);
    {branch, zero_flag} = 2'b00; step(); check("br_flush_drop", {31'd0, flush}, 32'd0);

    // MUL handshake at 0x40, mul_done in the 5th wait cycle
    take_branch(32'h40);
    n_stall = 0; n_start = 0;
    is_mul = 1'b1;
    step();
    check("mul_pc_hold", pc, 32'h40);
    for (int i = 0; i < 4; i++) step();
    check("mul_pc_hold5", pc, 32'h40);
    mul_done = 1'b1; is_mul = 1'b0;
    step();
    mul_done = 1'b0;
    check("mul_pc_next", pc, 32'h44);
    check("mul_stall_cycles", 32'(n_stall), 32'd5);
    check("mul_start_pulses", 32'(n_start), 32'd1);
    check("mul_err_clear", {31'd0, mul_err}, 32'd0);

    // MUL timeout
    n_stall = 0; n_start = 0;
    is_mul = 1'b1;
    step();
    for (int n = 0; n < 20 && stall; n++) step();
    is_mul = 1'b0;
    check("to_stall_cycles", 32'(n_stall), 32'(TO));
    check("to_err", {31'd0, mul_err}, 32'd1);
    check("to_pc", pc, 32'h48);
    mul_done = 1'b1; step(); mul_done = 1'b0;
    check("late_done_pc", pc, 32'h4C);
    step();
    check("to_err_sticky", {31'd0, mul_err}, 32'd1);
    check("late_done_no_start", 32'(n_start), 32'd1);

    // wrap
    take_branch(32'hFFFF_FFFC);
    check("wrap_pre", pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc", pc, 32'h0);

    // branch beats mul
    n_start = 0;
    branch = 1'b1; zero_flag = 1'b1; is_mul = 1'b1; branch_target = 32'h1234_5678;
    step();
    branch = 1'b0; zero_flag = 1'b0; is_mul = 1'b0;
    check("simul_pc", pc, 32'h1234_5678);
    check("simul_no_start", 32'(n_start), 32'd0);
    check("simul_stall", {31'd0, stall}, 32'd0);

    // misaligned taken branch
    take_branch(32'h1234_567B);
    check("misalign_pc", pc, TRAP_ON ? TRAP : 32'h1234_5678);
    check("misalign_flag", {31'd0, misalign}, {31'd0, TRAP_ON});

    // en=0 holds everything
    begin
      logic [31:0] held;
      held = pc;
      en = 1'b0;
      step(); step();
      check("en0_hold", pc, held);
      en = 1'b1;
      step();
      check("en1_resume", pc, held + 32'd4);
    end

    // async reset in the 3rd wait cycle
    is_mul = 1'b1;
    step(); step(); step();
    check("pre_rst_stall", {31'd0, stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_pc", pc, RPC);
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_err", {31'd0, mul_err}, 32'd0);
    is_mul = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mul_done = 1'b1; step(); mul_done = 1'b0;
    check("post_rst_pc", pc, 32'h4);
    check("post_rst_err", {31'd0, mul_err}, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
